// File: rtl/assoc_cache_set.sv
// assoc_cache_set: one fully associative cache set with WAYS lines.
// Supports lookup, fill (with round-robin replacement when full),
// invalidate and a sequential flush that evicts valid lines one way per cycle.
// All responses and evictions are registered and appear the cycle after the
// triggering clock edge.
module assoc_cache_set #(
    parameter int WAYS   = 16,
    parameter int TAG_W  = 27,
    parameter int DATA_W = 64,
    localparam int WAY_W = $clog2(WAYS),
    localparam int OCC_W = $clog2(WAYS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_data,
    output logic [WAY_W-1:0]  rsp_way,
    output logic              evict_valid,
    output logic [TAG_W-1:0]  evict_tag,
    output logic [DATA_W-1:0] evict_data,
    output logic [OCC_W-1:0]  occupancy
);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [WAY_W-1:0]   scan_q, scan_d;
    logic [WAY_W-1:0]   ptr_q, ptr_d;
    logic [WAYS-1:0]    valid_q, valid_d;

    // Line storage (not reset; qualified by valid_q)
    logic [TAG_W-1:0]   tag_q  [WAYS];
    logic [DATA_W-1:0]  data_q [WAYS];

    // Registered outputs
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
    logic               evict_valid_q, evict_valid_d;
    logic [TAG_W-1:0]   evict_tag_q, evict_tag_d;
    logic [DATA_W-1:0]  evict_data_q, evict_data_d;

    // Line write port
    logic               wr_en;
    logic [WAY_W-1:0]   wr_way;

    // Search results
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               free_found;
    logic [WAY_W-1:0]   free_way;
    logic [OCC_W-1:0]   occ;

    // Tag match and lowest free way; tags are unique among valid ways
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w] && (tag_q[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    // Occupancy is the population count of valid bits
    always_comb begin
        occ = '0;
        for (int w = 0; w < WAYS; w++) begin
            occ = occ + OCC_W'(valid_q[w]);
        end
    end

    // Next-state and response decode for IDLE requests and the flush scan
    always_comb begin
        state_d       = state_q;
        scan_d        = scan_q;
        ptr_d         = ptr_q;
        valid_d       = valid_q;
        rsp_valid_d   = 1'b0;
        rsp_hit_d     = 1'b0;
        rsp_data_d    = '0;
        rsp_way_d     = '0;
        evict_valid_d = 1'b0;
        evict_tag_d   = '0;
        evict_data_d  = '0;
        wr_en         = 1'b0;
        wr_way        = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    case (req_op)
                        OP_LOOKUP: begin
                            if (hit) begin
                                rsp_hit_d  = 1'b1;
                                rsp_data_d = data_q[hit_way];
                                rsp_way_d  = hit_way;
                            end
                        end
                        OP_FILL: begin
                            wr_en = 1'b1;
                            if (hit) begin
                                // Update in place; tag rewritten with same value
                                rsp_hit_d = 1'b1;
                                rsp_way_d = hit_way;
                                wr_way    = hit_way;
                            end else if (free_found) begin
                                valid_d[free_way] = 1'b1;
                                rsp_way_d         = free_way;
                                wr_way            = free_way;
                            end else begin
                                // Set full: replace the round-robin victim
                                evict_valid_d = 1'b1;
                                evict_tag_d   = tag_q[ptr_q];
                                evict_data_d  = data_q[ptr_q];
                                rsp_way_d     = ptr_q;
                                wr_way        = ptr_q;
                                ptr_d         = ptr_q + WAY_W'(1);
                            end
                        end
                        OP_INVAL: begin
                            if (hit) begin
                                valid_d[hit_way] = 1'b0;
                                rsp_hit_d        = 1'b1;
                                rsp_way_d        = hit_way;
                                evict_valid_d    = 1'b1;
                                evict_tag_d      = tag_q[hit_way];
                                evict_data_d     = data_q[hit_way];
                            end
                        end
                        OP_FLUSH: begin
                            // Response is deferred until the scan completes
                            rsp_valid_d = 1'b0;
                            state_d     = ST_FLUSH;
                            scan_d      = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (valid_q[scan_q]) begin
                    valid_d[scan_q] = 1'b0;
                    evict_valid_d   = 1'b1;
                    evict_tag_d     = tag_q[scan_q];
                    evict_data_d    = data_q[scan_q];
                end
                if (scan_q == LAST_WAY) begin
                    state_d     = ST_IDLE;
                    scan_d      = '0;
                    ptr_d       = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    scan_d = scan_q + WAY_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            scan_q        <= '0;
            ptr_q         <= '0;
            valid_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_way_q     <= '0;
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            scan_q        <= scan_d;
            ptr_q         <= ptr_d;
            valid_q       <= valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_data_q    <= rsp_data_d;
            rsp_way_q     <= rsp_way_d;
            evict_valid_q <= evict_valid_d;
            evict_tag_q   <= evict_tag_d;
            evict_data_q  <= evict_data_d;
        end
    end

    // Tag/data array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_way]  <= req_tag;
            data_q[wr_way] <= req_data;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_way     = rsp_way_q;
    assign evict_valid = evict_valid_q;
    assign evict_tag   = evict_tag_q;
    assign evict_data  = evict_data_q;
    assign occupancy   = occ;

endmodule
